// File: rtl/collision_edge_detector_if.sv
// Pixel-stream inputs and collision-report outputs of the collision edge detector.
// slave = detector side, master = pixel source / report consumer side.
interface collision_edge_detector_if;
    logic               startOfFrame;
    logic signed [10:0] pixelX;
    logic signed [10:0] pixelY;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               smileyDrawingRequest;
    logic               brickDrawingRequest;
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic               lockoutActive;

    modport slave (
        input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
               smileyDrawingRequest, brickDrawingRequest,
        output collision, HitEdgeCode, lockoutActive
    );

    modport master (
        output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
               smileyDrawingRequest, brickDrawingRequest,
        input  collision, HitEdgeCode, lockoutActive
    );
endinterface

// File: rtl/collision_edge_detector.sv
// Classifies smiley/brick overlap pixels by smiley edge, reports once per frame.
// Latency: report pulse one clock after the startOfFrame that closes the frame.
// Backpressure: none; every pixel is sampled each clock, reports are fire-and-forget.
module collision_edge_detector #(
    parameter int OBJ_WIDTH      = 32,
    parameter int OBJ_HEIGHT     = 32,
    parameter int EDGE_MARGIN    = 4,
    parameter int LOCKOUT_FRAMES = 2
) (
    input  logic                      clk,
    input  logic                      resetN,
    collision_edge_detector_if.slave  bus
);

    localparam int CW = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;

    localparam logic signed [11:0] W_S    = 12'(OBJ_WIDTH);
    localparam logic signed [11:0] H_S    = 12'(OBJ_HEIGHT);
    localparam logic signed [11:0] M_S    = 12'(EDGE_MARGIN);
    localparam logic signed [11:0] R_TH_S = 12'(OBJ_WIDTH - EDGE_MARGIN);
    localparam logic signed [11:0] B_TH_S = 12'(OBJ_HEIGHT - EDGE_MARGIN);

    typedef enum logic [1:0] {
        S_ACCUM   = 2'd0,
        S_REPORT  = 2'd1,
        S_LOCKOUT = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         acc;
    logic [CW-1:0]      lock_cnt;

    logic signed [11:0] off_x;
    logic signed [11:0] off_y;
    logic               in_box;
    logic [3:0]         edge_bits;
    logic               sample_vld;

    // Sign-extend before subtracting so extreme coordinates cannot wrap.
    assign off_x = {bus.pixelX[10], bus.pixelX} - {bus.topLeftX[10], bus.topLeftX};
    assign off_y = {bus.pixelY[10], bus.pixelY} - {bus.topLeftY[10], bus.topLeftY};

    assign in_box = !off_x[11] && (off_x < W_S) && !off_y[11] && (off_y < H_S);

    assign edge_bits = in_box ? {(off_x < M_S), (off_y < M_S),
                                 (off_x >= R_TH_S), (off_y >= B_TH_S)} : 4'b0000;

    assign sample_vld = bus.smileyDrawingRequest & bus.brickDrawingRequest
                      & in_box & ~bus.startOfFrame;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state             <= S_ACCUM;
            acc               <= 4'b0000;
            lock_cnt          <= '0;
            bus.collision     <= 1'b0;
            bus.HitEdgeCode   <= 4'b0000;
            bus.lockoutActive <= 1'b0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (bus.startOfFrame) begin
                        if (acc != 4'b0000) begin
                            bus.HitEdgeCode   <= acc;
                            acc               <= 4'b0000;
                            state             <= S_REPORT;
                            bus.collision     <= 1'b1;
                            bus.lockoutActive <= 1'b1;
                        end
                    end else if (sample_vld) begin
                        acc <= acc | edge_bits;
                    end
                end

                // Frame pulses seen here are deliberately not counted toward lockout.
                S_REPORT: begin
                    bus.collision <= 1'b0;
                    acc           <= 4'b0000;
                    if (LOCKOUT_FRAMES == 0) begin
                        state             <= S_ACCUM;
                        bus.lockoutActive <= 1'b0;
                    end else begin
                        state    <= S_LOCKOUT;
                        lock_cnt <= CW'(LOCKOUT_FRAMES);
                    end
                end

                S_LOCKOUT: begin
                    acc <= 4'b0000;
                    if (bus.startOfFrame) begin
                        if (lock_cnt <= CW'(1)) begin
                            lock_cnt          <= '0;
                            state             <= S_ACCUM;
                            bus.lockoutActive <= 1'b0;
                        end else begin
                            lock_cnt <= lock_cnt - CW'(1);
                        end
                    end
                end

                default: begin
                    state             <= S_ACCUM;
                    acc               <= 4'b0000;
                    lock_cnt          <= '0;
                    bus.collision     <= 1'b0;
                    bus.lockoutActive <= 1'b0;
                end
            endcase
        end
    end

endmodule
